// File: rtl/merge_tree_stream_if.sv
// Leaf-FIFO, output-FIFO and status signals of the merge tree as one bundle.
interface merge_tree_stream_if #(
   parameter int LEAVES     = 8,
   parameter int DATA_WIDTH = 32
);
   logic [LEAVES*DATA_WIDTH-1:0] i_fifo;
   logic [LEAVES-1:0]            i_fifo_empty;
   logic                         i_fifo_out_ready;
   logic [LEAVES-1:0]            o_fifo_read;
   logic                         o_out_fifo_write;
   logic [DATA_WIDTH-1:0]        o_data;
   logic [15:0]                  o_run_count;
   logic [31:0]                  o_rec_count;
   logic                         o_idle;

   // the block under control sees leaf heads and output readiness as inputs
   modport slave (
      input  i_fifo, i_fifo_empty, i_fifo_out_ready,
      output o_fifo_read, o_out_fifo_write, o_data, o_run_count, o_rec_count, o_idle
   );

   // the surrounding sort stage (leaf FIFOs, output FIFO) drives the other side
   modport master (
      output i_fifo, i_fifo_empty, i_fifo_out_ready,
      input  o_fifo_read, o_out_fifo_write, o_data, o_run_count, o_rec_count, o_idle
   );
endinterface

// File: rtl/merge_tree_stream.sv
// Streaming merge tree: LEAVES sorted leaf streams -> one ascending stream.
// Nodes use heap numbering: node 1 is the root, node n reads streams 2n and
// 2n+1. Stream index LEAVES+k is leaf FIFO k; stream index n in 2..LEAVES-1
// is the 2-entry coupler written by node n. Runs end with an all-ones key.
module merge_tree_stream #(
   parameter int LEAVES     = 8,
   parameter int DATA_WIDTH = 32,
   parameter int KEY_WIDTH  = 32
) (
   input logic                 i_clk,
   input logic                 i_rst_n,
   merge_tree_stream_if.slave  bus
);
   localparam int NIDX = 2 * LEAVES;

   // stream heads seen by the nodes and per-stream pop strobes
   logic [NIDX-1:1]       vld;
   logic [DATA_WIDTH-1:0] dat [1:NIDX-1];
   logic [NIDX-1:1]       pop;

   // node outputs: push[1] is the root fire
   logic [LEAVES-1:1]     push;
   logic [DATA_WIDTH-1:0] push_dat [1:LEAVES-1];

   // coupler storage: e0 is the head entry
   logic [1:0]            cnt_q [2:LEAVES-1];
   logic [1:0]            cnt_d [2:LEAVES-1];
   logic [DATA_WIDTH-1:0] e0_q  [2:LEAVES-1];
   logic [DATA_WIDTH-1:0] e0_d  [2:LEAVES-1];
   logic [DATA_WIDTH-1:0] e1_q  [2:LEAVES-1];
   logic [DATA_WIDTH-1:0] e1_d  [2:LEAVES-1];

   logic                  write_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic [15:0]           run_count_q;
   logic [31:0]           rec_count_q;
   logic                  couplers_empty;

   logic                  accept;
   logic                  term_a;
   logic                  term_b;
   logic                  both_term;
   logic                  sel_b;
   logic                  fire;

   // node decisions; all inputs are leaf heads or registered coupler state,
   // so there is no combinational ready path between levels
   always_comb begin
      vld       = '0;
      pop       = '0;
      push      = '0;
      accept    = 1'b0;
      term_a    = 1'b0;
      term_b    = 1'b0;
      both_term = 1'b0;
      sel_b     = 1'b0;
      fire      = 1'b0;
      for (int i = 1; i < NIDX; i++) begin
         dat[i] = '0;
      end
      for (int n = 1; n < LEAVES; n++) begin
         push_dat[n] = '0;
      end
      // leaves are masked during reset so no pop can escape
      for (int k = 0; k < LEAVES; k++) begin
         vld[LEAVES+k] = ~bus.i_fifo_empty[k] & i_rst_n;
         dat[LEAVES+k] = bus.i_fifo[k*DATA_WIDTH +: DATA_WIDTH];
      end
      for (int n = 2; n < LEAVES; n++) begin
         vld[n] = (cnt_q[n] != 2'd0);
         dat[n] = e0_q[n];
      end
      for (int n = 1; n < LEAVES; n++) begin
         accept    = (n == 1) ? bus.i_fifo_out_ready : (cnt_q[n] != 2'd2);
         term_a    = &dat[2*n][KEY_WIDTH-1:0];
         term_b    = &dat[2*n+1][KEY_WIDTH-1:0];
         both_term = term_a & term_b;
         // strict compare: equal keys go to input 0
         sel_b     = ~both_term &
                     (dat[2*n+1][KEY_WIDTH-1:0] < dat[2*n][KEY_WIDTH-1:0]);
         fire      = vld[2*n] & vld[2*n+1] & accept;
         push[n]     = fire;
         push_dat[n] = sel_b ? dat[2*n+1] : dat[2*n];
         pop[2*n]    = fire & ~sel_b;
         pop[2*n+1]  = fire & (sel_b | both_term);
      end
   end

   // coupler next state; push and pop together keep occupancy unchanged
   always_comb begin
      for (int n = 2; n < LEAVES; n++) begin
         cnt_d[n] = cnt_q[n];
         e0_d[n]  = e0_q[n];
         e1_d[n]  = e1_q[n];
         case ({push[n], pop[n]})
            2'b10: begin
               if (cnt_q[n] == 2'd0) e0_d[n] = push_dat[n];
               else                  e1_d[n] = push_dat[n];
               cnt_d[n] = cnt_q[n] + 2'd1;
            end
            2'b01: begin
               e0_d[n]  = e1_q[n];
               cnt_d[n] = cnt_q[n] - 2'd1;
            end
            2'b11: begin
               if (cnt_q[n] == 2'd1) begin
                  e0_d[n] = push_dat[n];
               end else begin
                  e0_d[n] = e1_q[n];
                  e1_d[n] = push_dat[n];
               end
            end
            default: ;
         endcase
      end
   end

   // coupler registers; reset discards anything in flight
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int n = 2; n < LEAVES; n++) begin
            cnt_q[n] <= 2'd0;
            e0_q[n]  <= '0;
            e1_q[n]  <= '0;
         end
      end else begin
         for (int n = 2; n < LEAVES; n++) begin
            cnt_q[n] <= cnt_d[n];
            e0_q[n]  <= e0_d[n];
            e1_q[n]  <= e1_d[n];
         end
      end
   end

   // root output register and run/record counters
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         write_q     <= 1'b0;
         data_q      <= '0;
         run_count_q <= '0;
         rec_count_q <= '0;
      end else begin
         write_q <= push[1];
         if (push[1]) begin
            data_q <= push_dat[1];
            if (&push_dat[1][KEY_WIDTH-1:0]) run_count_q <= run_count_q + 16'd1;
            else                             rec_count_q <= rec_count_q + 32'd1;
         end
      end
   end

   // idle when nothing is buffered in any coupler
   always_comb begin
      couplers_empty = 1'b1;
      for (int n = 2; n < LEAVES; n++) begin
         if (cnt_q[n] != 2'd0) couplers_empty = 1'b0;
      end
   end

   assign bus.o_fifo_read      = pop[NIDX-1:LEAVES];
   assign bus.o_out_fifo_write = write_q;
   assign bus.o_data           = data_q;
   assign bus.o_run_count      = run_count_q;
   assign bus.o_rec_count      = rec_count_q;
   assign bus.o_idle           = couplers_empty & ~write_q;

endmodule
